stage_scroll_ctrl: RTL

//  Per-frame sequencer for the scrolling ground stage. Owns the game-phase FSM (idle/run/pause/dead).

---
 rtl/flappy_pkg.sv | 23 ++
 rtl/mod_add_wrap.sv | 45 ++++
 rtl/stage_scroll_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// ============================================================================
// Module      : flappy_pkg
// Description : Shared game-phase encoding and stage geometry constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DEAD  = 2'd3
    } game_state_t;

    localparam int TEXEL_SCALE  = 4;
    // One ground pattern repeat is 7 texels wide.
    localparam int SHIFT_PERIOD = TEXEL_SCALE * 7;

endpackage : flappy_pkg

`default_nettype wire

// File: rtl/mod_add_wrap.sv
// ============================================================================
// Module      : mod_add_wrap
// Description : Registered accumulator that adds a step modulo PERIOD.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_add_wrap #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 4,
    parameter int PERIOD = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [STEP_W-1:0] i_step,
    output logic [WIDTH-1:0]  o_value
);

    localparam logic [WIDTH:0] c_PERIOD = (WIDTH+1)'(PERIOD);

    logic [WIDTH-1:0] r_value;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_wrapped;

    // One extra bit keeps the sum exact before the single wrap subtraction.
    assign w_sum     = {1'b0, r_value} + (WIDTH+1)'(i_step);
    assign w_wrapped = (w_sum >= c_PERIOD) ? (w_sum - c_PERIOD) : w_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (i_clr) begin
            r_value <= '0;
        end else if (i_en) begin
            r_value <= WIDTH'(w_wrapped);
        end
    end

    assign o_value = r_value;

endmodule : mod_add_wrap

`default_nettype wire

// File: rtl/stage_scroll_ctrl.sv
// ============================================================================
// Module      : stage_scroll_ctrl
// Description : Game-phase FSM and per-frame stage scroll sequencer.
//               Optional speed ramp: define SCROLL_CTRL_SPEEDUP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_scroll_ctrl
    import flappy_pkg::*;
#(
    parameter int SHIFT_PERIOD   = flappy_pkg::SHIFT_PERIOD,
    parameter int BASE_SPEED     = 2,
    parameter int MAX_SPEED      = 6,
    parameter int SPEEDUP_FRAMES = 600,
    parameter int DEAD_FRAMES    = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_end,
    input  logic        start,
    input  logic        hit,
    input  logic        pause,
    output logic        new_frame,
    output logic [15:0] shift,
    output logic [3:0]  speed,
    output logic [1:0]  state,
    output logic        scrolling
);

    generate
        if (BASE_SPEED < 1 || BASE_SPEED > 15 || BASE_SPEED >= SHIFT_PERIOD ||
            MAX_SPEED < BASE_SPEED || MAX_SPEED > 15 || MAX_SPEED >= SHIFT_PERIOD ||
            SPEEDUP_FRAMES < 1 || DEAD_FRAMES < 1) begin : g_param_err
            $error("stage_scroll_ctrl: illegal speed/period/frame parameters");
        end
    endgenerate

    localparam int                 c_DCW      = $clog2(DEAD_FRAMES + 1);
    localparam logic [c_DCW-1:0]   c_DEAD_MAX = c_DCW'(DEAD_FRAMES);
    localparam logic [3:0]         c_BASE     = 4'(BASE_SPEED);

    game_state_t      r_state;
    game_state_t      w_state_next;
    logic [c_DCW-1:0] r_dead_cnt;
    logic             r_new_frame;
    logic             w_dead_done;
    logic             w_enter_dead;
    logic             w_enter_idle;
    logic             w_scroll_now;

    assign w_dead_done  = (r_dead_cnt >= c_DEAD_MAX);
    assign w_scroll_now = (r_state == ST_IDLE) || (r_state == ST_RUN);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_RUN;
            ST_RUN: begin
                if (hit)        w_state_next = ST_DEAD;
                else if (pause) w_state_next = ST_PAUSE;
            end
            ST_PAUSE: if (pause) w_state_next = ST_RUN;
            // A premature start is simply dropped.
            ST_DEAD:  if (start && w_dead_done) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign w_enter_dead = (r_state != ST_DEAD) && (w_state_next == ST_DEAD);
    assign w_enter_idle = (r_state == ST_DEAD) && (w_state_next == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_new_frame <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_new_frame <= frame_end;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dead_cnt <= '0;
        end else if (w_enter_dead) begin
            r_dead_cnt <= '0;
        end else if ((r_state == ST_DEAD) && frame_end && !w_dead_done) begin
            r_dead_cnt <= r_dead_cnt + 1'b1;
        end
    end

`ifdef SCROLL_CTRL_SPEEDUP_EN
    localparam int               c_FCW  = $clog2(SPEEDUP_FRAMES + 1);
    localparam logic [c_FCW-1:0] c_LAST = c_FCW'(SPEEDUP_FRAMES - 1);
    localparam logic [3:0]       c_MAX  = 4'(MAX_SPEED);

    logic [c_FCW-1:0] r_frame_cnt;
    logic [3:0]       r_speed;

    // Frames only accrue while running; PAUSE and DEAD freeze the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_speed     <= c_BASE;
        end else if (w_enter_idle) begin
            r_frame_cnt <= '0;
            r_speed     <= c_BASE;
        end else if ((r_state == ST_RUN) && frame_end) begin
            if (r_frame_cnt == c_LAST) begin
                r_frame_cnt <= '0;
                r_speed     <= (r_speed >= c_MAX) ? c_MAX : (r_speed + 4'd1);
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign speed = r_speed;
`else
    assign speed = c_BASE;
`endif

    // Scroll decision uses the pre-transition state.
    mod_add_wrap #(
        .WIDTH  (16),
        .STEP_W (4),
        .PERIOD (SHIFT_PERIOD)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .i_en    (frame_end && w_scroll_now),
        .i_clr   (w_enter_idle),
        .i_step  (speed),
        .o_value (shift)
    );

    assign new_frame = r_new_frame;
    assign state     = r_state;
    assign scrolling = w_scroll_now;

endmodule : stage_scroll_ctrl

`default_nettype wire
